// File: rtl/instr_queue_dispatch.sv
// In-order instruction queue dispatching to arithmetic, RAM and load/store units.
// Latency: push to issue >= 1 cycle; a full queue drops pushes unless the head pops the same cycle; a unit switch waits for busy units.
module instr_queue_dispatch #(
  parameter int LOG_QUEUE_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       queue_we,
  input  logic [1:0]                 queue_instr_type,
  input  logic [0:8]                 queue_arith_instr,
  input  logic [0:2]                 queue_ram_instr,
  input  logic [0:6]                 queue_ld_st_instr,
  input  logic [17:0]                cache_addr,
  input  logic [17:0]                main_mem_addr,
  input  logic [17:0]                d_cache_addr,
  input  logic [17:0]                d_main_mem_addr,
  output logic                       queue_full,
  output logic [LOG_QUEUE_DEPTH:0]   queue_count,
  output logic                       arith_valid,
  input  logic                       arith_ready,
  output logic [0:8]                 arith_instr,
  output logic                       ram_valid,
  input  logic                       ram_ready,
  output logic [0:2]                 ram_instr,
  output logic [17:0]                ram_cache_addr,
  output logic [17:0]                ram_main_mem_addr,
  output logic [17:0]                ram_d_cache_addr,
  output logic [17:0]                ram_d_main_mem_addr,
  output logic                       ldst_valid,
  input  logic                       ldst_ready,
  output logic [0:6]                 ldst_instr,
  output logic [17:0]                ldst_cache_addr,
  output logic [17:0]                ldst_d_cache_addr,
  input  logic                       arith_busy,
  input  logic                       ram_busy,
  input  logic                       ldst_busy,
  output logic                       overflow_err,
  output logic                       illegal_err,
  output logic [15:0]                issued_count
);

  localparam int DEPTH = 1 << LOG_QUEUE_DEPTH;
  localparam int CW    = LOG_QUEUE_DEPTH + 1;

  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd0;
  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd1;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd2;

  typedef enum logic {ST_ISSUE, ST_DRAIN} state_t;

  typedef struct packed {
    logic [1:0]  itype;
    logic [0:8]  arith;
    logic [0:2]  ram;
    logic [0:6]  ldst;
    logic [17:0] cache_addr;
    logic [17:0] main_mem_addr;
    logic [17:0] d_cache_addr;
    logic [17:0] d_main_mem_addr;
  } entry_t;

  entry_t                     mem [DEPTH];
  entry_t                     head_e;
  entry_t                     wr_e;
  logic [LOG_QUEUE_DEPTH-1:0] head;
  logic [LOG_QUEUE_DEPTH-1:0] tail;
  logic [CW-1:0]              count;
  state_t                     state;
  logic [1:0]                 last_type;

  logic empty;
  logic any_busy;
  logic type_switch;
  logic issue_ok;
  logic legal;
  logic pop;
  logic push;

  always_comb begin
    wr_e = '{itype:           queue_instr_type,
             arith:           queue_arith_instr,
             ram:             queue_ram_instr,
             ldst:            queue_ld_st_instr,
             cache_addr:      cache_addr,
             main_mem_addr:   main_mem_addr,
             d_cache_addr:    d_cache_addr,
             d_main_mem_addr: d_main_mem_addr};
  end

  assign head_e      = mem[head];
  assign empty       = (count == '0);
  assign queue_full  = (count == CW'(DEPTH));
  assign queue_count = count;
  assign any_busy    = arith_busy | ram_busy | ldst_busy;
  assign type_switch = (head_e.itype != last_type);

  // Valids come only from registered queue state and busy, never from ready.
  assign issue_ok    = (state == ST_ISSUE) && !empty && !(type_switch && any_busy);
  assign arith_valid = issue_ok && (head_e.itype == INSTR_TYPE_ARITHMETIC);
  assign ram_valid   = issue_ok && (head_e.itype == INSTR_TYPE_RAM);
  assign ldst_valid  = issue_ok && (head_e.itype == INSTR_TYPE_LOAD_STORE);

  assign pop   = (arith_valid && arith_ready) || (ram_valid && ram_ready) ||
                 (ldst_valid && ldst_ready);
  assign legal = (queue_instr_type == INSTR_TYPE_ARITHMETIC) ||
                 (queue_instr_type == INSTR_TYPE_RAM) ||
                 (queue_instr_type == INSTR_TYPE_LOAD_STORE);
  assign push  = queue_we && legal && (!queue_full || pop);

  assign arith_instr         = head_e.arith;
  assign ram_instr           = head_e.ram;
  assign ram_cache_addr      = head_e.cache_addr;
  assign ram_main_mem_addr   = head_e.main_mem_addr;
  assign ram_d_cache_addr    = head_e.d_cache_addr;
  assign ram_d_main_mem_addr = head_e.d_main_mem_addr;
  assign ldst_instr          = head_e.ldst;
  assign ldst_cache_addr     = head_e.cache_addr;
  assign ldst_d_cache_addr   = head_e.d_cache_addr;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_e;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= ST_ISSUE;
      last_type    <= INSTR_TYPE_RAM;
      overflow_err <= 1'b0;
      illegal_err  <= 1'b0;
      issued_count <= '0;
    end else begin
      if (push) tail <= tail + LOG_QUEUE_DEPTH'(1);
      if (pop) begin
        head         <= head + LOG_QUEUE_DEPTH'(1);
        issued_count <= issued_count + 16'd1;
        last_type    <= head_e.itype;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (queue_we && !legal) illegal_err <= 1'b1;
      if (queue_we && legal && queue_full && !pop) overflow_err <= 1'b1;
      case (state)
        ST_ISSUE: if (!empty && type_switch && any_busy) state <= ST_DRAIN;
        ST_DRAIN: if (!any_busy) state <= ST_ISSUE;
        default:  state <= ST_ISSUE;
      endcase
    end
  end

endmodule
